// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
// ----------------
// EX/MEM pipeline boundary register. It captures the EX-stage shifter/ALU
// result, destination register, memory controls and store data on each
// rising clock edge. It also holds the architectural Z/V/N flag register.
// The hazard unit can hold the register (stall) or load a bubble (flush).
//
// Priority on each edge: reset (rst_n low) > flush > stall > load.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   stall, flush   hazard-unit controls
//   ex_*           EX-stage result, store data, destination and controls
//   ex_flag_en     per-flag update mask {Z,V,N}
//   ex_v, ex_n     overflow and sign from the adder
//   mem_*          registered MEM-side copies; control bits are qualified by valid
//   flag_z/v/n     registered flag register
//   stall_cnt      saturating count of stall cycles
//   flush_cnt      saturating count of flushes
//
// Optional build macro EXMEM_PERF_EN:
//   Defined   : builds stall_cnt and flush_cnt as saturating counters.
//   Undefined : no counter flops are built; both count outputs are tied to 0.
//   The port list is the same in both builds.

module ex_mem_stage_reg #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [2:0]        ex_flag_en,
  input  logic              ex_v,
  input  logic              ex_n,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              valid_reg;
  logic [DATA_W-1:0] result_reg;
  logic [DATA_W-1:0] store_data_reg;
  logic [REG_AW-1:0] rd_reg;
  logic              regwrite_reg;
  logic              memread_reg;
  logic              memwrite_reg;
  logic              z_reg;
  logic              v_reg;
  logic              n_reg;

  // Flag writes are allowed only on a real load edge. A flushed, stalled or
  // invalid slot never changes the flags.
  logic flag_load;
  assign flag_load = ex_valid && !flush && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      result_reg     <= '0;
      store_data_reg <= '0;
      rd_reg         <= '0;
      regwrite_reg   <= 1'b0;
      memread_reg    <= 1'b0;
      memwrite_reg   <= 1'b0;
      z_reg          <= 1'b0;
      v_reg          <= 1'b0;
      n_reg          <= 1'b0;
    end else if (flush) begin
      // Bubble: clear the MEM-side contents. The flags are left unchanged.
      valid_reg      <= 1'b0;
      result_reg     <= '0;
      store_data_reg <= '0;
      rd_reg         <= '0;
      regwrite_reg   <= 1'b0;
      memread_reg    <= 1'b0;
      memwrite_reg   <= 1'b0;
    end else if (!stall) begin
      valid_reg      <= ex_valid;
      result_reg     <= ex_result;
      store_data_reg <= ex_store_data;
      rd_reg         <= ex_rd;
      // An invalid EX slot must never start a register-file or memory write.
      regwrite_reg   <= ex_regwrite && ex_valid;
      memread_reg    <= ex_memread  && ex_valid;
      memwrite_reg   <= ex_memwrite && ex_valid;
      if (flag_load) begin
        if (ex_flag_en[2]) z_reg <= (ex_result == '0);
        if (ex_flag_en[1]) v_reg <= ex_v;
        if (ex_flag_en[0]) n_reg <= ex_n;
      end
    end
  end

  assign mem_valid      = valid_reg;
  assign mem_result     = result_reg;
  assign mem_store_data = store_data_reg;
  assign mem_rd         = rd_reg;
  assign mem_regwrite   = regwrite_reg;
  assign mem_memread    = memread_reg;
  assign mem_memwrite   = memwrite_reg;
  assign flag_z         = z_reg;
  assign flag_v         = v_reg;
  assign flag_n         = n_reg;

`ifdef EXMEM_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // Both counters saturate at all-ones instead of wrapping. A flush that
  // arrives together with a stall counts only as a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (flush && !(&flush_cnt_reg))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      if (stall && !flush && !(&stall_cnt_reg))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed scoreboard testbench for ex_mem_stage_reg.
// Before each clock edge, the stimulus process pushes the hand-computed
// MEM-side state expected after that edge. A monitor process pops and
// compares one entry shortly after every rising edge.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [15:0] ex_result;
  logic [15:0] ex_store_data;
  logic [3:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [2:0]  ex_flag_en;
  logic        ex_v;
  logic        ex_n;
  logic        mem_valid;
  logic [15:0] mem_result;
  logic [15:0] mem_store_data;
  logic [3:0]  mem_rd;
  logic        mem_regwrite;
  logic        mem_memread;
  logic        mem_memwrite;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_flag_en(ex_flag_en), .ex_v(ex_v), .ex_n(ex_n),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] result;
    logic [15:0] store;
    logic [3:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        z;
    logic        v;
    logic        n;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passes = 0;

  // Counter outputs read 0 unless the counters are built.
  function automatic logic [15:0] pc(input int x);
`ifdef EXMEM_PERF_EN
    return x[15:0];
`else
    return (x == 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  function automatic exp_t mk(input logic valid, input logic [15:0] result,
                              input logic [15:0] store, input logic [3:0] rd,
                              input logic rw, input logic mr, input logic mw,
                              input logic z, input logic v, input logic n,
                              input int sc, input int fc);
    exp_t e;
    e.valid = valid; e.result = result; e.store = store; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.z = z; e.v = v; e.n = n;
    e.scnt = pc(sc); e.fcnt = pc(fc);
    return e;
  endfunction

  task automatic set_ex(input logic valid, input logic [15:0] result,
                        input logic [15:0] store, input logic [3:0] rd,
                        input logic rw, input logic mr, input logic mw,
                        input logic [2:0] fen, input logic v, input logic n);
    ex_valid = valid; ex_result = result; ex_store_data = store; ex_rd = rd;
    ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
    ex_flag_en = fen; ex_v = v; ex_n = n;
  endtask

  // Inputs are already set at a falling edge. Queue the expectation for the
  // next rising edge, then move on to the following falling edge.
  task automatic step(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  // Monitor: sample 1 ns after each rising edge.
  initial begin
    exp_t  e;
    exp_t  a;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {mem_valid, mem_result, mem_store_data, mem_rd, mem_regwrite,
             mem_memread, mem_memwrite, flag_z, flag_v, flag_n, stall_cnt, flush_cnt};
        checks++;
        if (a === e) begin
          passes++;
          $display("check %-12s ok  state=%h", t, a);
        end else begin
          $display("FAIL %-12s got=%h expected=%h", t, a, e);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_ex(1'b1, 16'hFFFF, 16'hFFFF, 4'hF, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1, 1'b1);
    @(negedge clk);

    // Reset is held for two edges while EX presents a full-ones instruction.
    step("rst0", mk(0, 16'h0000, 16'h0000, 4'd0, 0,0,0, 0,0,0, 0,0));
    step("rst1", mk(0, 16'h0000, 16'h0000, 4'd0, 0,0,0, 0,0,0, 0,0));
    rst_n = 1'b1;

    // SLL of 0 with the Z-only mask sets Z. V and N are not in the mask.
    set_ex(1, 16'h0000, 16'h0005, 4'd3, 1,0,0, 3'b100, 1,1);
    step("sll_z", mk(1, 16'h0000, 16'h0005, 4'd3, 1,0,0, 1,0,0, 0,0));
    // ADD with a full mask.
    set_ex(1, 16'h8000, 16'h0000, 4'd4, 1,0,0, 3'b111, 1,1);
    step("add_zvn", mk(1, 16'h8000, 16'h0000, 4'd4, 1,0,0, 0,1,1, 0,0));
    // SRA with the Z-only mask: V and N hold.
    set_ex(1, 16'hFFFF, 16'h0000, 4'd5, 1,0,0, 3'b100, 0,0);
    step("sra_hold", mk(1, 16'hFFFF, 16'h0000, 4'd5, 1,0,0, 0,1,1, 0,0));
    // Load 1234 with no flag update.
    set_ex(1, 16'h1234, 16'h0000, 4'd6, 1,0,0, 3'b000, 0,0);
    step("ld1234", mk(1, 16'h1234, 16'h0000, 4'd6, 1,0,0, 0,1,1, 0,0));
    // Stall for 3 cycles while EX changes: contents and flags hold.
    set_ex(1, 16'hABCD, 16'h0000, 4'd7, 1,0,0, 3'b111, 0,0);
    stall = 1'b1;
    step("stall1", mk(1, 16'h1234, 16'h0000, 4'd6, 1,0,0, 0,1,1, 1,0));
    step("stall2", mk(1, 16'h1234, 16'h0000, 4'd6, 1,0,0, 0,1,1, 2,0));
    step("stall3", mk(1, 16'h1234, 16'h0000, 4'd6, 1,0,0, 0,1,1, 3,0));
    stall = 1'b0;
    step("unstall", mk(1, 16'hABCD, 16'h0000, 4'd7, 1,0,0, 0,0,0, 3,0));
    // Flush beats stall. The Z update from result 0 is discarded.
    set_ex(1, 16'h0000, 16'h1111, 4'd8, 1,1,1, 3'b100, 0,0);
    stall = 1'b1; flush = 1'b1;
    step("flush_stall", mk(0, 16'h0000, 16'h0000, 4'd0, 0,0,0, 0,0,0, 3,1));
    stall = 1'b0; flush = 1'b0;
    // Invalid slot: controls are masked and the flags do not change.
    set_ex(0, 16'h0000, 16'h0077, 4'd9, 1,1,1, 3'b111, 1,1);
    step("invalid", mk(0, 16'h0000, 16'h0077, 4'd9, 0,0,0, 0,0,0, 3,1));
    // Store.
    set_ex(1, 16'h0010, 16'hBEEF, 4'd2, 0,0,1, 3'b000, 0,0);
    step("store", mk(1, 16'h0010, 16'hBEEF, 4'd2, 0,0,1, 0,0,0, 3,1));
    // Load producing zero sets Z.
    set_ex(1, 16'h0000, 16'h0000, 4'd1, 1,1,0, 3'b100, 0,0);
    step("load_z", mk(1, 16'h0000, 16'h0000, 4'd1, 1,1,0, 1,0,0, 3,1));
    // Flush alone: Z stays 1 even though the incoming result is nonzero.
    set_ex(1, 16'h0005, 16'h0000, 4'd4, 1,0,0, 3'b111, 1,1);
    flush = 1'b1;
    step("flush_only", mk(0, 16'h0000, 16'h0000, 4'd0, 0,0,0, 1,0,0, 3,2));
    // Reset beats flush and stall, and clears the flags and counters.
    stall = 1'b1; rst_n = 1'b0;
    step("rst_mid", mk(0, 16'h0000, 16'h0000, 4'd0, 0,0,0, 0,0,0, 0,0));
    rst_n = 1'b1; flush = 1'b0; stall = 1'b0;
    set_ex(0, 16'h0000, 16'h0000, 4'd0, 0,0,0, 3'b000, 0,0);
    step("idle", mk(0, 16'h0000, 16'h0000, 4'd0, 0,0,0, 0,0,0, 0,0));

`ifdef EXMEM_PERF_EN
    // Drive 2^16+5 stall edges. The stall counter must stop at all-ones.
    stall = 1'b1;
    repeat (65536 + 4) @(negedge clk);
    step("stall_sat", mk(0, 16'h0000, 16'h0000, 4'd0, 0,0,0, 0,0,0, 65535,0));
    stall = 1'b0;
`endif

    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain got=%0d expected=0 pending entries", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
